// File: rtl/tt_um_accelshark_psg_voice_gen2.sv
// rtl/tt_um_accelshark_psg_voice_gen2.sv - PSG voice: tone/noise source with pan, volume and linear decay envelope
module tt_um_accelshark_psg_voice_gen2 #(
    parameter int PITCH_W          = 8,
    parameter int VOL_W            = 4,
    parameter int OCTAVE_W         = 2,
    parameter int OCTAVE_PREDIVIDE = 2,
    parameter int ENV_PRESCALE     = 4,
    parameter int ENV_RATE_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [1:0]            pan,
    input  logic [OCTAVE_W-1:0]   octave,
    input  logic [PITCH_W-1:0]    pitch,
    input  logic [VOL_W-1:0]      volume,
    input  logic                  noise_en,
    input  logic                  env_en,
    input  logic [ENV_RATE_W-1:0] env_rate,
    input  logic                  key_on,
    output logic [VOL_W:0]        mix_l,
    output logic [VOL_W:0]        mix_r,
    output logic                  phase_tick
);

    localparam int NOCT  = 2 ** OCTAVE_W;
    localparam int DIV_W = OCTAVE_PREDIVIDE + NOCT - 1;

    logic [DIV_W-1:0]        div_cnt;
    logic [DIV_W-1:0]        oct_mask;
    logic                    oct_tick;
    logic [PITCH_W-1:0]      pitch_cnt;
    logic                    phase_evt;
    logic                    phase_evt_q;
    logic                    square;
    logic [14:0]             lfsr;
    logic                    key_q;
    logic                    key_edge;
    logic [ENV_PRESCALE-1:0] env_pre;
    logic                    env_tick;
    logic [ENV_RATE_W-1:0]   env_rate_cnt;
    logic [VOL_W-1:0]        env_level;
    logic                    wave;
    logic [VOL_W-1:0]        amp;
    logic [VOL_W:0]          amp_pos;
    logic [VOL_W:0]          amp_neg;
    logic [VOL_W:0]          sample;

    // Highest octave compares the fewest low bits; each octave step down adds one bit.
    assign oct_mask  = {DIV_W{1'b1}} >> octave;
    assign oct_tick  = (div_cnt & oct_mask) == oct_mask;
    assign phase_evt = oct_tick && (pitch_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            pitch_cnt <= '0;
        end else if (ena) begin
            div_cnt <= div_cnt + DIV_W'(1);
            if (oct_tick) begin
                if (pitch_cnt == '0) begin
                    pitch_cnt <= pitch;
                end else begin
                    pitch_cnt <= pitch_cnt - PITCH_W'(1);
                end
            end
        end
    end

    // Square and LFSR both advance on every phase event so switching modes keeps them in step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            square      <= 1'b0;
            lfsr        <= 15'd1;
            phase_evt_q <= 1'b0;
            phase_tick  <= 1'b0;
        end else if (ena) begin
            if (phase_evt) begin
                square <= ~square;
                lfsr   <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            end
            phase_evt_q <= phase_evt;
            phase_tick  <= phase_evt_q;
        end
    end

    assign key_edge = key_on && !key_q;
    assign env_tick = &env_pre;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q        <= 1'b0;
            env_pre      <= '0;
            env_rate_cnt <= '0;
            env_level    <= '0;
        end else if (ena) begin
            key_q <= key_on;
            if (key_edge) begin
                env_level    <= volume;
                env_rate_cnt <= env_rate;
                env_pre      <= '0;
            end else begin
                env_pre <= env_pre + ENV_PRESCALE'(1);
                if (env_tick) begin
                    if (env_rate_cnt == '0) begin
                        env_rate_cnt <= env_rate;
                        if (env_level != '0) begin
                            env_level <= env_level - VOL_W'(1);
                        end
                    end else begin
                        env_rate_cnt <= env_rate_cnt - ENV_RATE_W'(1);
                    end
                end
            end
        end
    end

    assign wave    = noise_en ? lfsr[0] : square;
    assign amp     = env_en ? env_level : volume;
    assign amp_pos = {1'b0, amp};
    assign amp_neg = ~amp_pos + (VOL_W+1)'(1);
    assign sample  = wave ? amp_pos : amp_neg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix_l <= '0;
            mix_r <= '0;
        end else if (ena) begin
            mix_l <= (pan[0] && amp != '0) ? sample : '0;
            mix_r <= (pan[1] && amp != '0) ? sample : '0;
        end
    end

endmodule

// File: tb/tb_tt_um_accelshark_psg_voice_gen2.sv
// tb/tb_tt_um_accelshark_psg_voice_gen2.sv - directed and randomized checks of the PSG voice against a cycle model
module tb_tt_um_accelshark_psg_voice_gen2;

    localparam int OCTAVE_PREDIVIDE = 2;
    localparam int NOCT             = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] pan;
    logic [1:0] octave;
    logic [7:0] pitch;
    logic [3:0] volume;
    logic       noise_en;
    logic       env_en;
    logic [3:0] env_rate;
    logic       key_on;
    logic [4:0] mix_l;
    logic [4:0] mix_r;
    logic       phase_tick;

    int vectors     = 0;
    int miscompares = 0;

    int m_cyc, m_pcnt, m_sq, m_lfsr, m_key_prev, m_level, m_rcnt, m_epre, m_pe_d;
    logic [4:0] exp_l, exp_r;
    logic       exp_tick;

    tt_um_accelshark_psg_voice_gen2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pan        (pan),
        .octave     (octave),
        .pitch      (pitch),
        .volume     (volume),
        .noise_en   (noise_en),
        .env_en     (env_en),
        .env_rate   (env_rate),
        .key_on     (key_on),
        .mix_l      (mix_l),
        .mix_r      (mix_r),
        .phase_tick (phase_tick)
    );

    always #5 clk = ~clk;

    // Reference: what the voice must do at the coming clock edge, from the current inputs.
    task automatic model_step();
        int k, period, amp, wave, sval;
        bit tick, pe, edge_k;
        if (!rst_n) begin
            m_cyc = 0; m_pcnt = 0; m_sq = 0; m_lfsr = 1; m_key_prev = 0;
            m_level = 0; m_rcnt = 0; m_epre = 0; m_pe_d = 0;
            exp_l = '0; exp_r = '0; exp_tick = 1'b0;
        end else if (ena) begin
            k      = OCTAVE_PREDIVIDE + (NOCT - 1) - int'(octave);
            period = 1 << k;
            tick   = (m_cyc % period) == (period - 1);
            pe     = tick && (m_pcnt == 0);
            wave   = noise_en ? (m_lfsr & 1) : m_sq;
            amp    = env_en ? m_level : int'(volume);
            sval   = wave ? amp : -amp;
            exp_l  = (pan[0] && amp != 0) ? 5'(sval) : 5'd0;
            exp_r  = (pan[1] && amp != 0) ? 5'(sval) : 5'd0;
            exp_tick = m_pe_d[0];
            m_pe_d   = pe ? 1 : 0;
            if (tick) m_pcnt = (m_pcnt == 0) ? int'(pitch) : m_pcnt - 1;
            if (pe) begin
                m_sq   = 1 - m_sq;
                m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
            end
            edge_k     = key_on && (m_key_prev == 0);
            m_key_prev = key_on ? 1 : 0;
            if (edge_k) begin
                m_level = int'(volume);
                m_rcnt  = int'(env_rate);
                m_epre  = 0;
            end else begin
                if (m_epre == 15) begin
                    if (m_rcnt == 0) begin
                        m_rcnt = int'(env_rate);
                        if (m_level > 0) m_level = m_level - 1;
                    end else begin
                        m_rcnt = m_rcnt - 1;
                    end
                end
                m_epre = (m_epre + 1) % 16;
            end
            m_cyc = m_cyc + 1;
        end
    endtask

    task automatic check_outputs();
        vectors++;
        assert (mix_l === exp_l) else begin
            miscompares++;
            $error("FAIL mix_l: observed %h expected %h", mix_l, exp_l);
        end
        vectors++;
        assert (mix_r === exp_r) else begin
            miscompares++;
            $error("FAIL mix_r: observed %h expected %h", mix_r, exp_r);
        end
        vectors++;
        assert (phase_tick === exp_tick) else begin
            miscompares++;
            $error("FAIL phase_tick: observed %b expected %b", phase_tick, exp_tick);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
    endtask

    task automatic check_const(input string tag, input logic [4:0] obs, input logic [4:0] req);
        vectors++;
        assert (obs === req) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; pan = 2'b11; octave = 2'd3; pitch = 8'd0;
        volume = 4'd15; noise_en = 1'b0; env_en = 1'b0; env_rate = 4'd0; key_on = 1'b0;

        // T1: fastest square, full volume, both channels
        do_reset();
        check_const("reset_mix_l", mix_l, 5'h00);
        run(1);
        check_const("t1_first_mix_l", mix_l, 5'h11);
        run(3);
        check_const("t1_hold_mix_r", mix_r, 5'h11);
        run(1);
        check_const("t1_toggle_mix_l", mix_l, 5'h0f);
        check_const("t1_toggle_tick", {4'd0, phase_tick}, 5'h01);
        run(40);

        // T2: lowest octave, pitch change mid-count
        octave = 2'd0; pitch = 8'd3;
        do_reset();
        run(300);
        pitch = 8'd1;
        run(300);

        // T3: left only, then silent volume
        octave = 2'd3; pitch = 8'd2; pan = 2'b01; volume = 4'd7;
        run(60);
        volume = 4'd0;
        run(40);

        // T4: decay envelope and re-trigger
        pan = 2'b11; env_en = 1'b1; volume = 4'd4; env_rate = 4'd0; pitch = 8'd0;
        key_on = 1'b1;
        run(100);
        check_const("t4_decayed_mix_l", mix_l, 5'h00);
        key_on = 1'b0;
        run(3);
        key_on = 1'b1;
        run(40);
        env_rate = 4'd2;
        key_on = 1'b0; run(1); key_on = 1'b1;
        run(200);

        // T5: noise mode from reset
        env_en = 1'b0; volume = 4'd15; noise_en = 1'b1; octave = 2'd3; pitch = 8'd0;
        do_reset();
        run(2000);

        // T6: freeze, then reset mid-note
        noise_en = 1'b0;
        run(21);
        ena = 1'b0;
        run(50);
        ena = 1'b1;
        run(30);
        do_reset();
        check_const("t6_reset_mix_r", mix_r, 5'h00);
        run(20);

        // Randomized segments
        for (int seg = 0; seg < 25; seg++) begin
            pan      = 2'($urandom_range(0, 3));
            octave   = 2'($urandom_range(0, 3));
            pitch    = 8'($urandom_range(0, 5));
            volume   = 4'($urandom_range(0, 15));
            noise_en = 1'($urandom_range(0, 1));
            env_en   = 1'($urandom_range(0, 1));
            env_rate = 4'($urandom_range(0, 3));
            for (int c = 0; c < 120; c++) begin
                ena = ($urandom_range(0, 99) >= 8);
                if ($urandom_range(0, 99) < 4) key_on = ~key_on;
                rst_n = ($urandom_range(0, 999) >= 5);
                run(1);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
